// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data SRAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } rd_owner_t;

    localparam int MEM_ARB_STRB_W = 4;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive data grants taken while a fetch is waiting.
// Instantiated by mem_port_arbiter only when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    // Clear dominates; the count holds once it reaches the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (clr_i) begin
            starve_cnt_d = '0;
        end else if (inc_i && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign at_max_o = (starve_cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single SRAM port shared by fetch (i_*) and memory stage (d_*); data has priority.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      i_req,
    input  logic [ADDR_W-1:0]         i_addr,
    output logic                      i_gnt,
    output logic                      i_rvalid,
    output logic [DATA_W-1:0]         i_rdata,

    input  logic                      d_req,
    input  logic [MEM_ARB_STRB_W-1:0] d_wstrb,
    input  logic [ADDR_W-1:0]         d_addr,
    input  logic [DATA_W-1:0]         d_wdata,
    output logic                      d_gnt,
    output logic                      d_rvalid,
    output logic [DATA_W-1:0]         d_rdata,

    output logic                      sram_en,
    output logic [MEM_ARB_STRB_W-1:0] sram_we,
    output logic [ADDR_W-1:0]         sram_addr,
    output logic [DATA_W-1:0]         sram_wdata,
    input  logic [DATA_W-1:0]         sram_rdata
);

    // Byte strobes only make sense for a 32-bit word.
    if (DATA_W != 32) begin : g_bad_data_w
        $error("mem_port_arbiter: DATA_W must be 32");
    end
    if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
    end

    rd_owner_t rd_owner_q;
    rd_owner_t rd_owner_d;
    logic      starve_win;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic starve_at_max;

    mem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (d_gnt & i_req),
        .clr_i    (i_gnt | ~i_req),
        .at_max_o (starve_at_max)
    );

    assign starve_win = starve_at_max & i_req;
`else
    assign starve_win = 1'b0;
`endif

    // Grants are purely combinational and held low for the whole of reset.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (d_req && !starve_win) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    assign sram_en    = i_gnt | d_gnt;
    assign sram_we    = d_gnt ? d_wstrb : '0;
    assign sram_addr  = d_gnt ? d_addr : i_addr;
    assign sram_wdata = d_gnt ? d_wdata : '0;

    // Writes produce no response, so they leave the owner IDLE.
    always_comb begin
        rd_owner_d = IDLE;
        if (i_gnt) begin
            rd_owner_d = INST;
        end else if (d_gnt && (d_wstrb == '0)) begin
            rd_owner_d = DATA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner_q <= IDLE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    assign i_rvalid = (rd_owner_q == INST);
    assign d_rvalid = (rd_owner_q == DATA);
    assign i_rdata  = sram_rdata;
    assign d_rdata  = sram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences, and random traffic vs. a model.
module tb_mem_port_arbiter;

    localparam int SMAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_wstrb    (d_wstrb),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic [3:0]  d_wstrb;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] sram_rdata;
        logic        e_i_gnt;
        logic        e_d_gnt;
        logic        e_en;
        logic [3:0]  e_we;
        logic [31:0] e_addr;
        logic        e_i_rv;
        logic        e_d_rv;
    } vec_t;

    vec_t vecs[7];

    int          owner_m;
    int          waits_m;
    logic        ex_i_gnt;
    logic        ex_d_gnt;
    logic        starve;

    initial begin
        // rst, i_req, i_addr, d_req, wstrb, d_addr, d_wdata, rdata | i_gnt, d_gnt, en, we, addr, i_rv, d_rv
        vecs[0] = '{1'b1, 1'b1, 32'h0000_0040, 1'b1, 4'h0, 32'h0000_0080, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'hbfc0_0000, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 4'h0, 32'hbfc0_0000, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h2408_0001,
                    1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'hbfc0_0004, 1'b1, 4'h0, 32'h0000_1000, 32'h0, 32'h0,
                    1'b0, 1'b1, 1'b1, 4'h0, 32'h0000_1000, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hcafe_f00d,
                    1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 32'h0, 1'b1, 4'b0011, 32'h0000_2000, 32'hdead_beef, 32'h0,
                    1'b0, 1'b1, 1'b1, 4'b0011, 32'h0000_2000, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h5555_aaaa,
                    1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0};

        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wstrb = '0;
        d_addr = '0; d_wdata = '0; sram_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Directed vector table
        for (int k = 0; k < 7; k++) begin
            rst = vecs[k].rst; i_req = vecs[k].i_req; i_addr = vecs[k].i_addr;
            d_req = vecs[k].d_req; d_wstrb = vecs[k].d_wstrb; d_addr = vecs[k].d_addr;
            d_wdata = vecs[k].d_wdata; sram_rdata = vecs[k].sram_rdata;
            #1;
            chk($sformatf("v%0d i_gnt", k), 32'(i_gnt), 32'(vecs[k].e_i_gnt));
            chk($sformatf("v%0d d_gnt", k), 32'(d_gnt), 32'(vecs[k].e_d_gnt));
            chk($sformatf("v%0d sram_en", k), 32'(sram_en), 32'(vecs[k].e_en));
            chk($sformatf("v%0d sram_we", k), 32'(sram_we), 32'(vecs[k].e_we));
            chk($sformatf("v%0d i_rvalid", k), 32'(i_rvalid), 32'(vecs[k].e_i_rv));
            chk($sformatf("v%0d d_rvalid", k), 32'(d_rvalid), 32'(vecs[k].e_d_rv));
            if (vecs[k].e_en)
                chk($sformatf("v%0d sram_addr", k), sram_addr, vecs[k].e_addr);
            if (vecs[k].e_d_gnt)
                chk($sformatf("v%0d sram_wdata", k), sram_wdata, vecs[k].d_wdata);
            if (vecs[k].e_i_rv)
                chk($sformatf("v%0d i_rdata", k), i_rdata, vecs[k].sram_rdata);
            if (vecs[k].e_d_rv)
                chk($sformatf("v%0d d_rdata", k), d_rdata, vecs[k].sram_rdata);
            next_cycle();
        end

        // Both requesters held high: fetch gets every (SMAX+1)th slot only with the guard
        i_req = 1'b1; d_req = 1'b1; d_wstrb = 4'h0; i_addr = 32'h300; d_addr = 32'h400;
        for (int k = 0; k < 3 * (SMAX + 1); k++) begin
            #1;
            ex_i_gnt = GUARD && ((k % (SMAX + 1)) == SMAX);
            chk($sformatf("starve%0d i_gnt", k), 32'(i_gnt), 32'(ex_i_gnt));
            chk($sformatf("starve%0d d_gnt", k), 32'(d_gnt), 32'(!ex_i_gnt));
            next_cycle();
        end
        i_req = 1'b0; d_req = 1'b0;
        next_cycle();

        // Reset pulse in the cycle after an instruction grant drops the response
        i_req = 1'b1; i_addr = 32'h0000_0100;
        #1;
        chk("rmid grant", 32'(i_gnt), 32'd1);
        next_cycle();
        rst = 1'b1; i_req = 1'b0; sram_rdata = 32'h0bad_0bad;
        #1;
        chk("rmid i_rvalid in rst", 32'(i_rvalid), 32'd0);
        chk("rmid sram_en in rst", 32'(sram_en), 32'd0);
        next_cycle();
        rst = 1'b0;
        #1;
        chk("rmid i_rvalid after", 32'(i_rvalid), 32'd0);
        next_cycle();
        i_req = 1'b1; i_addr = 32'h0000_0104;
        #1;
        chk("rmid refetch gnt", 32'(i_gnt), 32'd1);
        chk("rmid refetch addr", sram_addr, 32'h0000_0104);
        next_cycle();
        i_req = 1'b0; sram_rdata = 32'h1234_5678;
        #1;
        chk("rmid refetch rvalid", 32'(i_rvalid), 32'd1);
        chk("rmid refetch rdata", i_rdata, 32'h1234_5678);
        chk("rmid refetch d_rvalid", 32'(d_rvalid), 32'd0);
        next_cycle();

        // Random traffic against the reference model (owner: 0 none, 1 fetch, 2 load)
        owner_m = 0;
        waits_m = 0;
        for (int n = 0; n < 400; n++) begin
            i_req      = ($urandom_range(0, 3) != 0);
            d_req      = ($urandom_range(0, 2) != 0);
            d_wstrb    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            i_addr     = $urandom;
            d_addr     = $urandom;
            d_wdata    = $urandom;
            sram_rdata = $urandom;
            starve     = GUARD && (waits_m >= SMAX) && i_req;
            ex_d_gnt   = d_req && !starve;
            ex_i_gnt   = i_req && !ex_d_gnt;
            #1;
            chk("rnd i_gnt", 32'(i_gnt), 32'(ex_i_gnt));
            chk("rnd d_gnt", 32'(d_gnt), 32'(ex_d_gnt));
            chk("rnd sram_en", 32'(sram_en), 32'(ex_i_gnt || ex_d_gnt));
            chk("rnd sram_we", 32'(sram_we), ex_d_gnt ? 32'(d_wstrb) : 32'd0);
            chk("rnd i_rvalid", 32'(i_rvalid), 32'(owner_m == 1));
            chk("rnd d_rvalid", 32'(d_rvalid), 32'(owner_m == 2));
            if (ex_d_gnt) begin
                chk("rnd sram_addr d", sram_addr, d_addr);
                chk("rnd sram_wdata", sram_wdata, d_wdata);
            end else if (ex_i_gnt) begin
                chk("rnd sram_addr i", sram_addr, i_addr);
            end
            if (owner_m == 1) chk("rnd i_rdata", i_rdata, sram_rdata);
            if (owner_m == 2) chk("rnd d_rdata", d_rdata, sram_rdata);
            if (ex_i_gnt)                        owner_m = 1;
            else if (ex_d_gnt && d_wstrb == 4'h0) owner_m = 2;
            else                                 owner_m = 0;
            if (ex_i_gnt || !i_req)              waits_m = 0;
            else if (ex_d_gnt && waits_m < SMAX) waits_m = waits_m + 1;
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
